// File: rtl/deinterleaver_prime_stream_if.sv
// Stream interface for the prime-step deinterleaver.
// Carries the interleaved input stream and the natural-order output stream.
// The master side is the producer/consumer pair; the slave side is the deinterleaver.
interface deinterleaver_prime_stream_if #(
    parameter int unsigned BITS = 8
);
    logic [BITS-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/deinterleaver_prime_stream.sv
// Streaming ping-pong block deinterleaver.
// Symbol i of an interleaved frame is written at address (P*i) mod N and the bank is read
// back in address order, giving out[(P*i) % N] = in[i]. Two banks let one frame fill while
// the previous one drains, sustaining one symbol per cycle.
// The interface BITS parameter must match the module BITS parameter.
module deinterleaver_prime_stream #(
    parameter int unsigned BITS = 8,
    parameter int unsigned N    = 10,
    parameter int unsigned P    = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    deinterleaver_prime_stream_if.slave    bus,
    output logic                           frame_err
);

    function automatic int unsigned gcd(input int unsigned a_in, input int unsigned b_in);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    // A step sharing a factor with N would map two symbols onto one address.
    if (N < 2 || N > 4096 || P < 1 || P >= N || gcd(P, N) != 1) begin : g_bad_params
        $error("deinterleaver_prime_stream: need 2<=N<=4096, 1<=P<N, gcd(P,N)=1");
    end

    localparam int unsigned CW = $clog2(N);
    // One extra bit so waddr + P can be held before the conditional subtract.
    localparam int unsigned AW = CW + 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [AW-1:0] STEP     = AW'(P);
    localparam logic [AW-1:0] MODULUS  = AW'(N);

    logic [BITS-1:0] mem [2][N];

    logic            wsel_q,  wsel_d;
    logic            rsel_q,  rsel_d;
    logic [1:0]      full_q,  full_d;
    logic [CW-1:0]   wcnt_q,  wcnt_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [AW-1:0]   waddr_sum;
    logic [CW-1:0]   rcnt_q,  rcnt_d;
    logic [BITS-1:0] out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q,  out_last_d;
    logic            frame_err_q, frame_err_d;

    logic            wr_fire;
    logic            wr_last;
    logic            rd_load;
    logic            rd_last;

    // Handshake qualifiers.
    always_comb begin
        wr_fire = bus.in_valid && !full_q[wsel_q];
        wr_last = (wcnt_q == LAST_IDX);
        rd_load = full_q[rsel_q] && (!out_valid_q || bus.out_ready);
        rd_last = (rcnt_q == LAST_IDX);
    end

    assign bus.in_ready  = !full_q[wsel_q];
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign frame_err     = frame_err_q;

    // Symbol storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wsel_q][waddr_q[CW-1:0]] <= bus.in_data;
        end
    end

    // Next-state for write pointer, read pointer, bank flags and output register.
    always_comb begin
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        full_d      = full_q;
        wcnt_d      = wcnt_q;
        waddr_d     = waddr_q;
        rcnt_d      = rcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = frame_err_q;
        waddr_sum   = waddr_q + STEP;

        if (wr_fire) begin
            // Frame closure follows the internal count; in_last is only checked.
            if (bus.in_last != wr_last) begin
                frame_err_d = 1'b1;
            end
            if (wr_last) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                wcnt_d         = '0;
                waddr_d        = '0;
            end else begin
                wcnt_d  = wcnt_q + 1'b1;
                waddr_d = (waddr_sum >= MODULUS) ? (waddr_sum - MODULUS) : waddr_sum;
            end
        end

        // Set and clear never hit the same bank: set needs !full, clear needs full.
        if (rd_load) begin
            out_data_d  = mem[rsel_q][rcnt_q];
            out_last_d  = rd_last;
            out_valid_d = 1'b1;
            if (rd_last) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = ~rsel_q;
                rcnt_d         = '0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any partial or complete frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            full_q      <= 2'b00;
            wcnt_q      <= '0;
            waddr_q     <= '0;
            rcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            full_q      <= full_d;
            wcnt_q      <= wcnt_d;
            waddr_q     <= waddr_d;
            rcnt_q      <= rcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Output register must hold while the consumer stalls.
    a_out_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q)
                                             && $stable(out_last_q)));

    // Write address always stays inside the bank.
    a_waddr_range: assert property (@(posedge clk) disable iff (reset)
        waddr_q < MODULUS);

endmodule

// File: tb/tb_deinterleaver_prime_stream.sv
// Self-checking bench: two deinterleavers (N=10,P=3 and N=13,P=5) driven by randomised
// producers/consumers and compared against a permutation model out[(P*i)%N] = in[i].
module tb_deinterleaver_prime_stream;

    logic clk;
    logic reset;
    int   cyc;

    int n_vec;
    int n_err;

    int src_q [2][$];
    int exp_q [2][$];
    int vprob [2];
    int rprob [2];
    int n_acc [2];
    int n_out [2];
    int in_stall [2];
    int acc_at_stall [2];
    int bubbles [2];
    bit seen_out [2];
    bit seen_valid [2];
    int last_acc_cyc [2];
    int first_val_cyc [2];

    logic [1:0]      in_ready_w;
    logic [1:0]      out_valid_w;
    logic [1:0]      out_last_w;
    logic [1:0]      frame_err_w;
    logic [1:0][7:0] out_data_w;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned NN = (k == 0) ? 10 : 13;
        localparam int unsigned PP = (k == 0) ? 3 : 5;

        deinterleaver_prime_stream_if #(.BITS(8)) bus ();
        logic frame_err;

        deinterleaver_prime_stream #(.BITS(8), .N(NN), .P(PP)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .bus       (bus),
            .frame_err (frame_err)
        );

        assign in_ready_w[k]  = bus.in_ready;
        assign out_valid_w[k] = bus.out_valid;
        assign out_last_w[k]  = bus.out_last;
        assign out_data_w[k]  = bus.out_data;
        assign frame_err_w[k] = frame_err;

        // Producer and consumer: drive just after the edge, retire at the negedge.
        initial begin
            int tmp;
            bus.in_valid  = 1'b0;
            bus.in_data   = '0;
            bus.in_last   = 1'b0;
            bus.out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                bus.out_ready = ($urandom_range(0, 99) < rprob[k]);
                if (src_q[k].size() > 0 && $urandom_range(0, 99) < vprob[k]) begin
                    tmp          = src_q[k][0];
                    bus.in_valid = 1'b1;
                    bus.in_data  = tmp[7:0];
                    bus.in_last  = tmp[8];
                end else begin
                    bus.in_valid = 1'b0;
                end
                @(negedge clk);
                if (!reset && bus.in_valid) begin
                    if (bus.in_ready) begin
                        tmp = src_q[k].pop_front();
                        n_acc[k]++;
                        if (tmp[8]) last_acc_cyc[k] = cyc;
                    end else begin
                        in_stall[k]++;
                        if (acc_at_stall[k] < 0) acc_at_stall[k] = n_acc[k];
                    end
                end
            end
        end

        // Output monitor: scoreboard compare, hold check while stalled, bubble count.
        initial begin
            int  e;
            bit  held;
            int  held_vec;
            held = 1'b0;
            held_vec = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    held = 1'b0;
                end else begin
                    if (held) begin
                        check("stall_hold", {22'b0, bus.out_valid, bus.out_last, bus.out_data},
                              held_vec);
                    end
                    held     = bus.out_valid && !bus.out_ready;
                    held_vec = {22'b0, 1'b1, bus.out_last, bus.out_data};
                    if (bus.out_valid && !seen_valid[k]) begin
                        seen_valid[k]    = 1'b1;
                        first_val_cyc[k] = cyc;
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 'hFFFF;
                        check($sformatf("out%0d_sym", k),
                              {23'b0, bus.out_last, bus.out_data}, e);
                        n_out[k]++;
                        seen_out[k] = 1'b1;
                    end else if (seen_out[k] && exp_q[k].size() > 0 && !bus.out_valid) begin
                        bubbles[k]++;
                    end
                end
            end
        end
    end

    // Reference model: symbol i lands at natural position (p*i) mod n.
    task automatic push_frame(input int k, input int n, input int p, input int vals[16],
                              input int last_idx);
        int e [16];
        for (int i = 0; i < n; i++) begin
            src_q[k].push_back(vals[i] | ((i == last_idx) ? 256 : 0));
            e[(p * i) % n] = vals[i];
        end
        for (int j = 0; j < n; j++) begin
            exp_q[k].push_back(e[j] | ((j == n - 1) ? 256 : 0));
        end
    endtask

    task automatic wait_drain(input int k, input int budget, input string tag);
        int c;
        c = 0;
        while ((src_q[k].size() != 0 || exp_q[k].size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(tag, src_q[k].size() + exp_q[k].size(), 0);
        @(negedge clk);
    endtask

    task automatic clear_stats(input int k);
        n_acc[k]        = 0;
        n_out[k]        = 0;
        in_stall[k]     = 0;
        acc_at_stall[k] = -1;
        bubbles[k]      = 0;
        seen_out[k]     = 1'b0;
        seen_valid[k]   = 1'b0;
    endtask

    task automatic check_reset_values(input int k, input string tag);
        check({tag, "_in_ready"},  int'(in_ready_w[k]),  1);
        check({tag, "_out_valid"}, int'(out_valid_w[k]), 0);
        check({tag, "_out_last"},  int'(out_last_w[k]),  0);
        check({tag, "_out_data"},  int'(out_data_w[k]),  0);
        check({tag, "_frame_err"}, int'(frame_err_w[k]), 0);
    endtask

    initial begin
        int vals [16];
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        for (int k = 0; k < 2; k++) begin
            vprob[k] = 0;
            rprob[k] = 0;
            clear_stats(k);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values(0, "rst0");
        check_reset_values(1, "rst1");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Natural-order input 0..9.
        vprob[0] = 100;
        rprob[0] = 100;
        clear_stats(0);
        for (int i = 0; i < 10; i++) vals[i] = i;
        push_frame(0, 10, 3, vals, 9);
        wait_drain(0, 200, "t1_drain");
        // Last input seen one negedge before its accepting edge; first output two negedges on.
        check("t1_latency", first_val_cyc[0] - last_acc_cyc[0], 2);
        check("t1_frame_err", int'(frame_err_w[0]), 0);

        // Round trip: forward-interleaved 0..9 comes back in order.
        for (int i = 0; i < 10; i++) vals[i] = (3 * i) % 10;
        push_frame(0, 10, 3, vals, 9);
        wait_drain(0, 200, "t2_drain");

        // Four back-to-back frames at full rate.
        clear_stats(0);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 10; i++) vals[i] = int'($urandom_range(0, 255));
            push_frame(0, 10, 3, vals, 9);
        end
        wait_drain(0, 300, "t3_drain");
        check("t3_in_stall", in_stall[0], 0);
        check("t3_bubbles", bubbles[0], 0);
        check("t3_out_count", n_out[0], 40);

        // Backpressure: consumer stalled while three frames are offered.
        clear_stats(0);
        rprob[0] = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 10; i++) vals[i] = int'($urandom_range(0, 255));
            push_frame(0, 10, 3, vals, 9);
        end
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("t4_stall_at", acc_at_stall[0], 20);
        check("t4_ready_low", int'(in_ready_w[0]), 0);
        rprob[0] = 100;
        wait_drain(0, 300, "t4_drain");
        check("t4_out_count", n_out[0], 30);

        // Random valid/ready, N=13 P=5, 20 frames.
        clear_stats(1);
        vprob[1] = 50;
        rprob[1] = 50;
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 13; i++) vals[i] = int'($urandom_range(0, 255));
            push_frame(1, 13, 5, vals, 12);
        end
        wait_drain(1, 5000, "t5_drain");
        check("t5_out_count", n_out[1], 260);
        check("t5_frame_err", int'(frame_err_w[1]), 0);

        // Misplaced in_last: error is flagged and sticky, frame still closes on count.
        clear_stats(0);
        for (int i = 0; i < 10; i++) vals[i] = int'($urandom_range(0, 255));
        push_frame(0, 10, 3, vals, 4);
        wait_drain(0, 200, "t6_drain_bad");
        check("t6_frame_err", int'(frame_err_w[0]), 1);
        for (int i = 0; i < 10; i++) vals[i] = int'($urandom_range(0, 255));
        push_frame(0, 10, 3, vals, 9);
        wait_drain(0, 200, "t6_drain_good");
        check("t6_err_sticky", int'(frame_err_w[0]), 1);

        // Reset with one full bank and one half-filled bank.
        rprob[0] = 0;
        for (int i = 0; i < 15; i++) src_q[0].push_back(int'($urandom_range(0, 255)));
        begin
            int c;
            c = 0;
            while (src_q[0].size() != 0 && c < 100) begin
                @(posedge clk);
                c++;
            end
        end
        @(negedge clk);
        check("t6_prefill", int'(out_valid_w[0]), 1);
        vprob[0] = 0;
        reset = 1'b1;
        #1;
        check_reset_values(0, "t6_rst");
        #1;
        src_q[0].delete();
        exp_q[0].delete();
        clear_stats(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vprob[0] = 100;
        rprob[0] = 100;
        for (int i = 0; i < 10; i++) vals[i] = int'($urandom_range(0, 255));
        push_frame(0, 10, 3, vals, 9);
        wait_drain(0, 200, "t6_drain_after_rst");
        check("t6_out_count", n_out[0], 10);
        check("t6_err_clear", int'(frame_err_w[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
